// File: rtl/sw_mem_server_if.sv
// Bundle between sw_mem_server, the host loader and the SmithWaterman core.
// Ports: host load beats (valid/ready/sel/last/data), SmithWaterman control and
// read port (start/busy/select/addr/data), run status (done, overflow, counts).
`ifndef SRAM_WORD_WIDTH
`define SRAM_WORD_WIDTH 8
`endif
`ifndef SRAM_ADDR_BIT
`define SRAM_ADDR_BIT 4
`endif

interface sw_mem_server_if #(
  parameter int WORD_W = `SRAM_WORD_WIDTH,
  parameter int ADDR_W = `SRAM_ADDR_BIT
);
  // host load side
  logic              host_valid_i;
  logic              host_ready_o;
  logic              host_sel_T_i;
  logic              host_last_i;
  logic [WORD_W-1:0] host_data_i;
  // SmithWaterman side
  logic              start_o;
  logic              busy_i;
  logic              select_T_i;
  logic [ADDR_W-1:0] addr_i;
  logic [WORD_W-1:0] data_o;
  // status
  logic              done_o;
  logic              overflow_o;
  logic [ADDR_W:0]   t_cnt_o;
  logic [ADDR_W:0]   q_cnt_o;

  modport slave (
    input  host_valid_i, host_sel_T_i, host_last_i, host_data_i,
    input  busy_i, select_T_i, addr_i,
    output host_ready_o, start_o, data_o, done_o, overflow_o, t_cnt_o, q_cnt_o
  );

  modport master (
    output host_valid_i, host_sel_T_i, host_last_i, host_data_i,
    output busy_i, select_T_i, addr_i,
    input  host_ready_o, start_o, data_o, done_o, overflow_o, t_cnt_o, q_cnt_o
  );
endinterface

// File: rtl/sw_mem_server.sv
// Memory server for a SmithWaterman core: host loads T and Q banks, block
// pulses start, serves registered reads (1-cycle latency) and signals done.
// Ports: clk, rst_n (async active-low), bus (sw_mem_server_if.slave).
`ifndef SRAM_WORD_WIDTH
`define SRAM_WORD_WIDTH 8
`endif
`ifndef SRAM_ADDR_BIT
`define SRAM_ADDR_BIT 4
`endif

module sw_mem_server #(
  parameter int WORD_W = `SRAM_WORD_WIDTH,
  parameter int ADDR_W = `SRAM_ADDR_BIT
) (
  input  logic            clk,
  input  logic            rst_n,
  sw_mem_server_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [WORD_W-1:0] t_mem [DEPTH];
  logic [WORD_W-1:0] q_mem [DEPTH];
  logic [ADDR_W:0]   t_cnt, q_cnt;
  logic [WORD_W-1:0] rd_dat;
  logic              done_q, ovf_q;
  logic              host_rdy, accept, t_full, q_full, t_wr, q_wr, run_end;

  assign host_rdy = (state == S_IDLE) || (state == S_LOAD);
  assign accept   = bus.host_valid_i && host_rdy;

  // Counts never exceed DEPTH, so the top bit alone marks a full bank.
  assign t_full = t_cnt[ADDR_W];
  assign q_full = q_cnt[ADDR_W];
  assign t_wr   = accept &&  bus.host_sel_T_i && !t_full;
  assign q_wr   = accept && !bus.host_sel_T_i && !q_full;

  assign run_end = (state == S_RUN) && !bus.busy_i;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = bus.host_last_i ? S_START : S_LOAD;
      S_LOAD:  if (accept && bus.host_last_i) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (bus.busy_i) state_nxt = S_RUN;
      S_RUN:   if (!bus.busy_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      t_cnt  <= '0;
      q_cnt  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      rd_dat <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= run_end;
      // Read uses the pre-edge memory contents, so a same-edge write to the
      // same address returns the old word.
      rd_dat <= bus.select_T_i ? t_mem[bus.addr_i] : q_mem[bus.addr_i];
      if (run_end) begin
        t_cnt <= '0;
        q_cnt <= '0;
      end else begin
        if (t_wr) t_cnt <= t_cnt + 1'b1;
        if (q_wr) q_cnt <= q_cnt + 1'b1;
      end
      // Beat to a full bank is still consumed; only the sticky flag records it.
      if (accept && (bus.host_sel_T_i ? t_full : q_full)) ovf_q <= 1'b1;
    end
  end

  // Memory arrays carry no reset so contents survive reset and run completion.
  always_ff @(posedge clk) begin
    if (t_wr) t_mem[t_cnt[ADDR_W-1:0]] <= bus.host_data_i;
    if (q_wr) q_mem[q_cnt[ADDR_W-1:0]] <= bus.host_data_i;
  end

  assign bus.host_ready_o = host_rdy;
  assign bus.start_o      = (state == S_START);
  assign bus.data_o       = rd_dat;
  assign bus.done_o       = done_q;
  assign bus.overflow_o   = ovf_q;
  assign bus.t_cnt_o      = t_cnt;
  assign bus.q_cnt_o      = q_cnt;

endmodule

// File: tb/tb_sw_mem_server.sv
// Directed self-checking bench for sw_mem_server (WORD_W=8, ADDR_W=4).
// Inputs driven 1 time unit after the rising edge; outputs checked there too.
module tb_sw_mem_server;

  localparam int WORD_W = 8;
  localparam int ADDR_W = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sw_mem_server_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  sw_mem_server #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One host beat presented for exactly one edge.
  task automatic beat(input logic sel_t, input logic last, input logic [WORD_W-1:0] dat);
    bus.host_valid_i = 1'b1;
    bus.host_sel_T_i = sel_t;
    bus.host_last_i  = last;
    bus.host_data_i  = dat;
    step();
    bus.host_valid_i = 1'b0;
    bus.host_last_i  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n            = 1'b0;
    bus.host_valid_i = 1'b0;
    bus.host_sel_T_i = 1'b0;
    bus.host_last_i  = 1'b0;
    bus.host_data_i  = '0;
    bus.busy_i       = 1'b0;
    bus.select_T_i   = 1'b0;
    bus.addr_i       = '0;

    // Reset values
    #3;
    check("rst_start",    32'(bus.start_o),    32'd0);
    check("rst_done",     32'(bus.done_o),     32'd0);
    check("rst_overflow", 32'(bus.overflow_o), 32'd0);
    check("rst_t_cnt",    32'(bus.t_cnt_o),    32'd0);
    check("rst_q_cnt",    32'(bus.q_cnt_o),    32'd0);
    check("rst_data",     32'(bus.data_o),     32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_ready", 32'(bus.host_ready_o), 32'd1);
    check("idle_start", 32'(bus.start_o),      32'd0);

    // Basic load: T A1, A2 then Q B1 last
    beat(1'b1, 1'b0, 8'hA1);
    check("load1_t_cnt", 32'(bus.t_cnt_o), 32'd1);
    check("load1_ready", 32'(bus.host_ready_o), 32'd1);
    beat(1'b1, 1'b0, 8'hA2);
    beat(1'b0, 1'b1, 8'hB1);
    check("load_t_cnt",  32'(bus.t_cnt_o),      32'd2);
    check("load_q_cnt",  32'(bus.q_cnt_o),      32'd1);
    check("start_pulse", 32'(bus.start_o),      32'd1);
    check("start_ready", 32'(bus.host_ready_o), 32'd0);

    // Reads during WAIT
    bus.select_T_i = 1'b1;
    bus.addr_i     = 4'd1;
    step();
    check("start_gone", 32'(bus.start_o), 32'd0);
    check("rd_t1",      32'(bus.data_o),  32'hA2);
    bus.select_T_i = 1'b0;
    bus.addr_i     = 4'd0;
    step();
    check("rd_q0",      32'(bus.data_o),  32'hB1);
    check("wait_ready", 32'(bus.host_ready_o), 32'd0);

    // Run for 10 busy cycles
    bus.busy_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("run_no_done", 32'(bus.done_o), 32'd0);
    end
    check("run_ready", 32'(bus.host_ready_o), 32'd0);
    bus.busy_i = 1'b0;
    step();
    check("done_pulse", 32'(bus.done_o),       32'd1);
    check("done_t_cnt", 32'(bus.t_cnt_o),      32'd0);
    check("done_q_cnt", 32'(bus.q_cnt_o),      32'd0);
    check("done_ready", 32'(bus.host_ready_o), 32'd1);
    step();
    check("done_gone",  32'(bus.done_o),       32'd0);
    check("q0_kept",    32'(bus.data_o),       32'hB1);

    // Load T 00,01,02,11; busy already high in START
    beat(1'b1, 1'b0, 8'h00);
    beat(1'b1, 1'b0, 8'h01);
    beat(1'b1, 1'b0, 8'h02);
    beat(1'b1, 1'b1, 8'h11);
    check("l2_start", 32'(bus.start_o), 32'd1);
    bus.busy_i = 1'b1;
    step();   // WAIT
    step();   // RUN straight away
    bus.busy_i = 1'b0;
    step();
    check("early_busy_done", 32'(bus.done_o), 32'd1);

    // Same-edge write/read of T address 3
    beat(1'b1, 1'b0, 8'h50);
    beat(1'b1, 1'b0, 8'h51);
    beat(1'b1, 1'b0, 8'h52);
    check("rbw_t_cnt", 32'(bus.t_cnt_o), 32'd3);
    bus.select_T_i = 1'b1;
    bus.addr_i     = 4'd3;
    beat(1'b1, 1'b1, 8'h22);
    check("rbw_old", 32'(bus.data_o), 32'h11);
    step();
    check("rbw_new", 32'(bus.data_o), 32'h22);
    bus.busy_i = 1'b1;
    step();
    bus.busy_i = 1'b0;
    step();
    check("rbw_done", 32'(bus.done_o), 32'd1);

    // Overflow: 2^ADDR_W + 1 T beats
    for (int i = 0; i < 16; i++) beat(1'b1, 1'b0, 8'(8'hC0 + i));
    check("full_t_cnt",    32'(bus.t_cnt_o),    32'd16);
    check("full_no_ovf",   32'(bus.overflow_o), 32'd0);
    check("full_ready",    32'(bus.host_ready_o), 32'd1);
    beat(1'b1, 1'b1, 8'hEE);
    check("ovf_t_cnt",     32'(bus.t_cnt_o),    32'd16);
    check("ovf_flag",      32'(bus.overflow_o), 32'd1);
    check("ovf_start",     32'(bus.start_o),    32'd1);
    bus.select_T_i = 1'b1;
    bus.addr_i     = 4'd0;
    step();
    check("ovf_word0",     32'(bus.data_o),     32'hC0);
    bus.addr_i     = 4'd15;
    step();
    check("ovf_word15",    32'(bus.data_o),     32'hCF);
    check("ovf_sticky",    32'(bus.overflow_o), 32'd1);

    // Reset while in WAIT
    rst_n = 1'b0;
    #1;
    check("wrst_start", 32'(bus.start_o),    32'd0);
    check("wrst_done",  32'(bus.done_o),     32'd0);
    check("wrst_ovf",   32'(bus.overflow_o), 32'd0);
    check("wrst_t_cnt", 32'(bus.t_cnt_o),    32'd0);
    check("wrst_data",  32'(bus.data_o),     32'd0);
    bus.busy_i = 1'b1;
    step();
    rst_n = 1'b1;
    // busy ignored in IDLE: no start, no done, still ready
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_done",  32'(bus.done_o),       32'd0);
      check("post_rst_start", 32'(bus.start_o),      32'd0);
      check("post_rst_ready", 32'(bus.host_ready_o), 32'd1);
    end
    bus.busy_i     = 1'b0;
    bus.select_T_i = 1'b1;
    bus.addr_i     = 4'd0;
    step();
    check("keep_t0",  32'(bus.data_o), 32'hC0);
    bus.addr_i     = 4'd15;
    step();
    check("keep_t15", 32'(bus.data_o), 32'hCF);
    bus.select_T_i = 1'b0;
    bus.addr_i     = 4'd0;
    step();
    check("keep_q0",  32'(bus.data_o), 32'hB1);
    check("keep_ovf", 32'(bus.overflow_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_mem_server.md
SW_MEM_SERVER -- requirements
Module: sw_mem_server

Interface
REQ-001 The block SHALL have a parameter WORD_W, default `SRAM_WORD_WIDTH, setting the SRAM word width.
REQ-002 The block SHALL have a parameter ADDR_W, default `SRAM_ADDR_BIT, setting the address width of each bank, which holds 2^ADDR_W words.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 host_valid_i  input  1  the host offers one load beat.
REQ-006 host_ready_o  output  1  the block accepts the load beat this cycle.
REQ-007 host_sel_T_i  input  1  selects the bank: 1 = target (T), 0 = query (Q).
REQ-008 host_last_i  input  1  marks the final beat of the load.
REQ-009 host_data_i  input  WORD_W  load word.
REQ-010 start_o  output  1  start pulse to the SmithWaterman start_i.
REQ-011 busy_i  input  1  SmithWaterman busy_o.
REQ-012 select_T_i  input  1  SmithWaterman select_T_o.
REQ-013 addr_i  input  ADDR_W  SmithWaterman addr_o.
REQ-014 data_o  output  WORD_W  read data to the SmithWaterman data_i.
REQ-015 done_o  output  1  one-cycle pulse when a run has completed.
REQ-016 overflow_o  output  1  sticky flag: a write was attempted to a full bank.
REQ-017 t_cnt_o / q_cnt_o  output  ADDR_W+1 each  number of words loaded into the T bank and the Q bank.

Function
REQ-018 The block SHALL contain two memories, T and Q, each WORD_W by 2^ADDR_W.
REQ-019 The FSM SHALL have five states, IDLE, LOAD, START, WAIT, RUN, with these transitions:
  - IDLE -> LOAD on the first accepted beat.
  - LOAD -> START on an accepted beat with host_last_i=1 (also taken directly from IDLE if the first beat is last).
  - START -> WAIT after exactly one cycle.
  - WAIT -> RUN when busy_i=1.
  - RUN -> IDLE when busy_i=0.
REQ-020 host_ready_o SHALL be 1 in IDLE and LOAD and 0 in START, WAIT and RUN; a beat is accepted only when host_valid_i and host_ready_o are both 1 in the same cycle.
REQ-021 An accepted beat SHALL write host_data_i into the selected bank at that bank's write pointer, and that pointer (t_cnt_o or q_cnt_o) SHALL increment by 1 in the same edge.
REQ-022 A beat to a bank whose count equals 2^ADDR_W SHALL be accepted but not written, its count SHALL hold, and overflow_o SHALL set; host_last_i on such a beat still advances the FSM.
REQ-023 start_o SHALL be 1 exactly in the START state, giving a one-cycle pulse.
REQ-024 On the RUN -> IDLE transition, done_o SHALL pulse for one cycle, both counts SHALL clear to 0, and memory contents SHALL be retained.
REQ-025 Read path:
  - data_o SHALL be registered: data_o is T[addr_i] when select_T_i=1, otherwise Q[addr_i], sampled on the edge, giving a latency of 1 cycle.
  - Reads SHALL be served in every state.
  - Addresses at or beyond the loaded count SHALL return stale contents; no error is raised.
REQ-026 A read and a write to the same bank and address on the same edge SHALL return the old word (read-before-write).
REQ-027 If busy_i is 1 during IDLE or LOAD it SHALL be ignored.
REQ-028 If busy_i is already 1 in START, WAIT SHALL exit to RUN on the next cycle.
REQ-029 overflow_o SHALL clear only on reset.
REQ-030 The write address SHALL be the low ADDR_W bits of the count; the count SHALL never wrap.

Reset
REQ-031 While rst_n=0, the block SHALL immediately force:
  - state to IDLE;
  - start_o=0, done_o=0, overflow_o=0;
  - t_cnt_o=0, q_cnt_o=0;
  - data_o=0;
  - host_ready_o to the IDLE value (1) once rst_n releases.
REQ-032 Reset SHALL NOT clear memory contents.
REQ-033 A reset asserted mid-load or mid-run SHALL abort the operation and emit no start_o or done_o pulse.

Verification
REQ-034 Load T beats 0xA1, 0xA2, then Q beat 0xB1 with last=1 -> t_cnt_o=2, q_cnt_o=1, start_o high for exactly 1 cycle, host_ready_o=0 from the next cycle.
REQ-035 After that load, select_T_i=1 with addr_i=1, then select_T_i=0 with addr_i=0 -> data_o=0xA2, then 0xB1, each 1 cycle after the address.
REQ-036 Hold busy_i=1 for 10 cycles after start_o, then drop it -> done_o pulses 1 cycle after busy_i falls, counts return to 0, host_ready_o=1.
REQ-037 Load 2^ADDR_W+1 T beats -> t_cnt_o stops at 2^ADDR_W, overflow_o=1, and word 0 is unchanged.
REQ-038 Assert rst_n=0 while in WAIT -> state IDLE, no done_o pulse, and a re-read of earlier-loaded data returns the same words.
REQ-039 Write and read T address 3 on the same edge (old 0x11, new 0x22) -> data_o=0x11, and the next read of address 3 returns 0x22.
